// File: rtl/enc_out_packer_if.sv
// Stream bundle for the encoder output packer: triple input side plus packed-word output side.
interface enc_out_packer_if;
   logic        in_valid;
   logic [2:0]  in_bits;
   logic        in_last;
   logic        out_ready;
   logic        out_valid;
   logic [23:0] out_data;
   logic [3:0]  out_nbits;
   logic        out_last;
   logic        overflow;
   logic        busy;

   modport master (
      output in_valid, in_bits, in_last, out_ready,
      input  out_valid, out_data, out_nbits, out_last, overflow, busy
   );

   modport slave (
      input  in_valid, in_bits, in_last, out_ready,
      output out_valid, out_data, out_nbits, out_last, overflow, busy
   );
endinterface

// File: rtl/enc_out_packer.sv
// Packs encoder triples LSB-first into three byte lanes and queues finished words
// in a small FIFO with a sticky overflow flag for words dropped on a full FIFO.
module enc_out_packer #(
   parameter int DEPTH = 4
) (
   input logic              clock,
   input logic              aclr,
   enc_out_packer_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int WW = 29;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    lane_q [3];
   logic [7:0]    lane_d [3];
   logic [7:0]    lane_nx_s [3];
   logic [WW-1:0] mem_q [DEPTH];
   logic [WW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          out_valid_q, out_valid_d;
   logic [23:0]   out_data_q, out_data_d;
   logic [3:0]    out_nbits_q, out_nbits_d;
   logic          out_last_q, out_last_d;
   logic          busy_q, busy_d;
   logic          push_s, pop_s, full_s, accept_s;
   logic [WW-1:0] word_s, head_s;

   // Bit packer: word layout is {last, nbits, lane2, lane1, lane0}.
   always_comb begin
      cnt_d  = cnt_q;
      push_s = 1'b0;
      word_s = {WW{1'b0}};
      for (int k = 0; k < 3; k++) begin
         lane_nx_s[k]         = lane_q[k];
         lane_nx_s[k][cnt_q]  = bus.in_bits[k];
         lane_d[k]            = lane_q[k];
      end
      if (bus.in_valid) begin
         if ((cnt_q == 3'd7) || bus.in_last) begin
            push_s = 1'b1;
            word_s = {bus.in_last, {1'b0, cnt_q} + 4'd1,
                      lane_nx_s[2], lane_nx_s[1], lane_nx_s[0]};
            cnt_d  = 3'd0;
            for (int k = 0; k < 3; k++) begin
               lane_d[k] = 8'd0;
            end
         end else begin
            cnt_d = cnt_q + 3'd1;
            for (int k = 0; k < 3; k++) begin
               lane_d[k] = lane_nx_s[k];
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Word FIFO: a simultaneous pop frees the slot a push into a full FIFO needs.
   always_comb begin
      full_s   = (count_q == FULL_CNT);
      pop_s    = out_valid_q & bus.out_ready;
      accept_s = push_s & (~full_s | pop_s);
      ovf_d    = ovf_q | (push_s & full_s & ~pop_s);
      mem_d    = mem_q;
      if (accept_s) begin
         mem_d[wr_q] = word_s;
         wr_d        = wr_q + AW'(1'b1);
      end else begin
         wr_d        = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + AW'(1'b1);
      end else begin
         rd_d = rd_q;
      end
      case ({accept_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Output staging: present next-cycle head so all outputs come straight from flops.
   always_comb begin
      head_s = mem_d[rd_d];
      if (count_d != {CW{1'b0}}) begin
         out_valid_d = 1'b1;
         out_data_d  = head_s[23:0];
         out_nbits_d = head_s[27:24];
         out_last_d  = head_s[28];
      end else begin
         out_valid_d = 1'b0;
         out_data_d  = 24'd0;
         out_nbits_d = 4'd0;
         out_last_d  = 1'b0;
      end
      busy_d = (cnt_d != 3'd0) || (count_d != {CW{1'b0}});
   end

   // State registers.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         cnt_q       <= 3'd0;
         for (int k = 0; k < 3; k++) begin
            lane_q[k] <= 8'd0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WW{1'b0}};
         end
         wr_q        <= {AW{1'b0}};
         rd_q        <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 24'd0;
         out_nbits_q <= 4'd0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         lane_q      <= lane_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_nbits_q <= out_nbits_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_nbits = out_nbits_q;
   assign bus.out_last  = out_last_q;
   assign bus.overflow  = ovf_q;
   assign bus.busy      = busy_q;

endmodule

// File: doc/enc_out_packer.md
ENC_OUT_PACKER -- requirements
Module: enc_out_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries in the output word FIFO (power of two, at least 2).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port aclr, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, encoder output triple valid; driven from the encoder controller out_valid.
REQ-005 SHALL have port in_bits, input, 3, encoded triple: bit0 systematic, bit1 parity1, bit2 parity2.
REQ-006 SHALL have port in_last, input, 1, marks the final triple of a code block; sampled only when in_valid=1.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts the current word.
REQ-008 SHALL have port out_valid, output, 1, FIFO head holds a word.
REQ-009 SHALL have port out_data, output, 24, packed word {parity2 byte, parity1 byte, systematic byte}.
REQ-010 SHALL have port out_nbits, output, 4, count of valid bits per byte lane, 1..8.
REQ-011 SHALL have port out_last, output, 1, word closes a code block.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a word was dropped.
REQ-013 SHALL have port busy, output, 1, partial byte pending or FIFO non-empty.

Function
REQ-014 SHALL keep a 3-bit bit counter cnt (0..7) and three 8-bit lane shift registers.
REQ-015 SHALL, when in_valid=1, write in_bits[k] into bit position cnt of lane k: first bit of a block in bit 0 of each byte (LSB-first).
REQ-016 SHALL, when in_valid=1 and (cnt=7 or in_last=1), form a word with out_nbits=cnt+1 and out_last=in_last, request a FIFO push, and set cnt to 0 and all lane registers to 0 in the same cycle.
REQ-017 SHALL, when in_valid=1 and no push condition applies, increment cnt by 1.
REQ-018 SHALL zero unused upper bits of a partial byte (out_nbits<8).
REQ-019 SHALL hold cnt and the lane registers unchanged while in_valid=0; in_last with in_valid=0 SHALL be ignored.
REQ-020 SHALL accept input every cycle with no backpressure toward the encoder.
REQ-021 SHALL make a pushed word visible at out_valid/out_data/out_nbits/out_last on the cycle after the triple that completed it, if it becomes the FIFO head.
REQ-022 SHALL pop the FIFO head on a cycle with out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive out_valid=1 exactly when the FIFO holds at least one word; words SHALL leave in push order.
REQ-024 SHALL accept a push on a full FIFO when a pop occurs in the same cycle, without setting overflow.
REQ-025 SHALL, on a push to a full FIFO with no simultaneous pop, discard the new word, leave the FIFO contents unchanged, and set overflow=1.
REQ-026 SHALL hold overflow at 1 until aclr.
REQ-027 SHALL drive busy=1 when cnt is not 0 or the FIFO is non-empty.
REQ-028 SHALL treat tail triples identically to data triples; block boundaries SHALL come only from in_last.

Reset
REQ-029 SHALL, while aclr=1, force cnt=0, lane registers=0, FIFO empty, out_valid=0, out_data=0, out_nbits=0, out_last=0, overflow=0, busy=0.
REQ-030 SHALL discard any partial block when aclr is asserted mid-block; the next accepted triple SHALL land at bit 0.

Verification
REQ-031 SHALL cover: 16 triples, in_bits=3'b111 on even and 3'b000 on odd, in_last on the 16th, out_ready=1 -> two words of 24'h555555, nbits=8, last=0 then 1.
REQ-032 SHALL cover: 10 triples of 3'b001 with in_last on the 10th -> word1 24'h0000FF nbits=8 last=0; word2 24'h000003 nbits=2 last=1.
REQ-033 SHALL cover: out_ready=0, 40 continuous triples -> 4 words held, 5th dropped, overflow=1; then out_ready=1 -> exactly 4 words out in order, overflow stays 1.
REQ-034 SHALL cover: FIFO full, out_ready=1 on the cycle a 5th word completes -> no drop, overflow=0, 5 words total delivered.
REQ-035 SHALL cover: aclr pulse after 5 triples -> all outputs 0 next cycle; a following 1-triple block 3'b101 with in_last -> 24'h010001, nbits=1, last=1.
